// File: rtl/bram_rd_stream.sv
// bram_rd_stream: turns a (base, len) command into one BRAM read per
// cycle and streams the returned words out through a credit-managed FIFO.
//
// Ports:
//   clk, rst (sync, active high), clk_en (global hold when low)
//   cmd_val/cmd_rdy/cmd_base_addr/cmd_len : command handshake
//   mem_rd_en/mem_rd_addr/mem_rd_data     : BRAM read port
//   out_data/out_val/out_rdy/out_last     : output stream
//   busy, done                            : status
//   cmd_err (only with BRAM_RD_STREAM_RANGE_CHK_EN defined): range reject
//
// Build option BRAM_RD_STREAM_RANGE_CHK_EN: reject commands whose range
// runs past the top of memory instead of wrapping the address.
module bram_rd_stream #(
  parameter int ADDR_WDT   = 10,
  parameter int DATA_WDT   = 32,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                cmd_val,
  output logic                cmd_rdy,
  input  logic [ADDR_WDT-1:0] cmd_base_addr,
  input  logic [ADDR_WDT:0]   cmd_len,
  output logic                mem_rd_en,
  output logic [ADDR_WDT-1:0] mem_rd_addr,
  input  logic [DATA_WDT-1:0] mem_rd_data,
  output logic [DATA_WDT-1:0] out_data,
  output logic                out_val,
  input  logic                out_rdy,
  output logic                out_last,
  output logic                busy,
  output logic                done
`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
  ,
  output logic                cmd_err
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam int LW = ADDR_WDT + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WDT-1:0] addr;
  logic [LW-1:0]       iss_left;
  logic [LW-1:0]       emit_left;

  // Valid/last pipes track each read through the BRAM latency.
  logic [RD_LAT-1:0]   vld_sr;
  logic [RD_LAT-1:0]   last_sr;

  logic [DATA_WDT-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         fifo_cnt;

  logic [CW-1:0]       inflight;
  logic [CW-1:0]       occ;
  logic                credit;
  logic                issue;
  logic                push;
  logic                pop;
  logic                accept;
  logic                cmd_bad;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + CW'(vld_sr[i]);
  end

  assign pop    = clk_en && (fifo_cnt != '0) && out_rdy;
  assign push   = clk_en && vld_sr[RD_LAT-1];

  // A word leaving this cycle frees its slot for a read issued now,
  // which keeps one word per cycle with FIFO_DEPTH = RD_LAT + 1.
  assign occ    = inflight + CW'(fifo_cnt) - CW'(pop);
  assign credit = occ < CW'(FIFO_DEPTH);

  assign issue  = clk_en && (state == ISSUE) && credit;
  assign accept = clk_en && cmd_val && (state == IDLE);

`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
  logic [ADDR_WDT+1:0] end_addr;
  logic                err_q;

  assign end_addr = (ADDR_WDT+2)'(cmd_base_addr)
                  + (ADDR_WDT+2)'(cmd_len);
  assign cmd_bad  = end_addr > (ADDR_WDT+2)'(2**ADDR_WDT);

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept)
      err_q <= cmd_bad;
  end
`else
  assign cmd_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else if (clk_en)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_rdy   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
    cmd_err   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          if ((cmd_len == '0) || cmd_bad)
            state_nxt = DONE;
          else
            state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (issue && (iss_left == LW'(1)))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if ((emit_left == '0) ||
            (pop && (emit_left == LW'(1))))
          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
        cmd_err = err_q;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      iss_left  <= '0;
      emit_left <= '0;
      vld_sr    <= '0;
      last_sr   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      fifo_last <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_data[i] <= '0;
    end else if (clk_en) begin
      if (accept) begin
        addr      <= cmd_base_addr;
        iss_left  <= cmd_len;
        emit_left <= cmd_len;
      end
      if (issue) begin
        addr     <= addr + 1'b1;
        iss_left <= iss_left - 1'b1;
      end
      vld_sr[0]  <= issue;
      last_sr[0] <= issue && (iss_left == LW'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      if (push) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_last[wr_ptr] <= last_sr[RD_LAT-1];
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        emit_left <= emit_left - 1'b1;
      end
      fifo_cnt <= fifo_cnt + (PW+1)'(push)
                           - (PW+1)'(pop);
    end
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr;
  assign out_val     = fifo_cnt != '0;
  assign out_data    = fifo_data[rd_ptr];
  assign out_last    = out_val && fifo_last[rd_ptr];

endmodule

// File: tb/tb_bram_rd_stream.sv
// tb_bram_rd_stream: directed/random command sequence against a BRAM
// model and a behavioural expectation of the output stream.
module tb_bram_rd_stream;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int DEP = 4;
  localparam int N   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          cmd_val;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_base_addr;
  logic [AW:0]   cmd_len;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data;
  logic          out_val;
  logic          out_rdy;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
  logic          cmd_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] bmem [N];
  logic [DW-1:0] pipe [LAT];

  always #5 clk = ~clk;

  // BRAM: LAT enabled cycles from enable to data; garbage when idle.
  always @(posedge clk) begin
    if (clk_en) begin
      pipe[0] <= mem_rd_en ? bmem[mem_rd_addr] : DW'($urandom);
      for (int k = 1; k < LAT; k++)
        pipe[k] <= pipe[k-1];
    end
  end
  assign mem_rd_data = pipe[LAT-1];

  bram_rd_stream #(
    .ADDR_WDT  (AW),
    .DATA_WDT  (DW),
    .RD_LAT    (LAT),
    .FIFO_DEPTH(DEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .cmd_val      (cmd_val),
    .cmd_rdy      (cmd_rdy),
    .cmd_base_addr(cmd_base_addr),
    .cmd_len      (cmd_len),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .out_data     (out_data),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
    ,
    .cmd_err      (cmd_err)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst_vals();
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
    chk("rst_cmd_err", cmd_err, 0);
`endif
  endtask

  // mode: 0 rdy high, 1 rdy 1-0-0-1, 2 random rdy, 3 clk_en low 1-in-3
  task automatic run_cmd(input int base, input int len,
                         input int mode, input int stop_after);
    int leff, issued, popped, ecnt, cyc;
    bit eerr, trig, dexp_prev, prev_en, fin_hs, finished;
    bit first_val, prev_val, prev_hs, prev_last;
    bit en, hs, done_exp, rdy_exp, aborted;
    logic [DW-1:0] prev_data;
    eerr = 1'b0;
`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
    eerr = (base + len) > N;
`endif
    leff = eerr ? 0 : len;
    @(negedge clk);
    cmd_val       = 1'b1;
    cmd_base_addr = AW'(base);
    cmd_len       = (AW+1)'(len);
    clk_en        = 1'b1;
    out_rdy       = 1'b1;
    #1;
    chk("acc_cmd_rdy", cmd_rdy, 1);
    chk("acc_busy", busy, 0);
    chk("acc_done", done, 0);
    issued = 0; popped = 0; ecnt = 1; cyc = 0;
    trig = (leff == 0); fin_hs = trig;
    dexp_prev = 0; prev_en = 1; finished = 0; aborted = 0;
    first_val = 0; prev_val = 0; prev_hs = 0;
    prev_last = 0; prev_data = '0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cmd_val       = 1'b0;
      cmd_base_addr = AW'($urandom);
      cmd_len       = (AW+1)'($urandom);
      en = (mode == 3) ? ((cyc % 3) != 2) : 1'b1;
      case (mode)
        1: out_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2: out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = 1'b1;
      endcase
      clk_en = en;
      #1;
      done_exp = trig || (dexp_prev && !prev_en);
      rdy_exp  = dexp_prev && prev_en;
      chk("done", done, done_exp);
      chk("busy", busy, (leff > 0) && !fin_hs);
      chk("cmd_rdy", cmd_rdy, rdy_exp);
`ifdef BRAM_RD_STREAM_RANGE_CHK_EN
      chk("cmd_err", cmd_err, done_exp && eerr);
`endif
      if (leff == 0)
        chk("zero_out_val", out_val, 0);
      if (mem_rd_en) begin
        chk("rd_in_range", issued < leff, 1);
        if (issued == 0)
          chk("first_rd_lat", ecnt, 1);
        chk("rd_addr", mem_rd_addr, (base + issued) % N);
        issued++;
      end
      if (prev_val && !prev_hs) begin
        chk("hold_val", out_val, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_val && !first_val) begin
        first_val = 1;
        chk("first_val_lat", ecnt, LAT + 2);
      end
      if (mode == 0 && first_val && popped < leff)
        chk("throughput", out_val, 1);
      hs = out_val && out_rdy && en;
      if (hs) begin
        chk("word_in_range", popped < leff, 1);
        if (popped < leff) begin
          chk("out_data", out_data, bmem[(base + popped) % N]);
          chk("out_last", out_last, popped == leff - 1);
        end
        popped++;
      end
      chk("occupancy", (issued - popped) <= DEP, 1);
      trig = hs && (popped == leff);
      if (trig) fin_hs = 1;
      if (en) ecnt++;
      prev_val  = out_val;
      prev_hs   = hs;
      prev_data = out_data;
      prev_last = out_last;
      dexp_prev = done_exp;
      prev_en   = en;
      if (rdy_exp) finished = 1;
      if (stop_after > 0 && popped == stop_after) begin
        finished = 1;
        aborted  = 1;
      end
      cyc++;
    end
    chk("no_timeout", finished, 1);
    if (!aborted)
      chk("word_count", popped, leff);
    clk_en  = 1'b1;
    out_rdy = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      bmem[i] = DW'($urandom);
    for (int k = 0; k < LAT; k++)
      pipe[k] = '0;
    rst = 1'b1; clk_en = 1'b1; cmd_val = 1'b0; out_rdy = 1'b0;
    cmd_base_addr = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    #1;
    check_rst_vals();
    @(negedge clk);
    rst = 1'b0;

    run_cmd(5, 8, 0, 0);
    run_cmd(100, 16, 1, 0);
    run_cmd(300, 0, 0, 0);
    run_cmd(N - 2, 4, 0, 0);
    run_cmd(40, 6, 3, 0);
    run_cmd(N - 1, 1, 0, 0);
    for (int t = 0; t < 6; t++)
      run_cmd(int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, 40)), 2, 0);

    run_cmd(int'($urandom_range(0, N - 1)), 32, 0, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_rst_vals();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_val", out_val, 0);
      chk("post_rst_rd", mem_rd_en, 0);
    end
    run_cmd(0, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_rd_stream.md
# bram_rd_stream

Read-stream controller that sits directly upstream of a single-port BRAM. It accepts a (base address, length) command and issues one read per cycle into the BRAM's memory interface. Returned words are buffered in a small credit-managed FIFO and emitted on a valid/ready stream with a last flag. It is the standard way for CNN datapath stages to pull weight/activation tiles out of on-chip memory without ever overflowing under backpressure.

## Interface
Parameters:
- ADDR_WDT, 10, BRAM address width.
- DATA_WDT, 32, BRAM word width.
- RD_LAT, 3, total BRAM read latency in enabled cycles (input pipe + array + output pipe), ≥1.
- FIFO_DEPTH, 4, output buffer depth in words, power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global enable; when low, every register holds, including the credit/valid pipe.
- cmd_val  in  1  command valid.
- cmd_rdy  out  1  command ready; high only in IDLE.
- cmd_base_addr  in  ADDR_WDT  first word address.
- cmd_len  in  ADDR_WDT+1  word count, 0 … 2^ADDR_WDT.
- mem_rd_en  out  1  BRAM enable (read, wr_en tied 0 by integrator).
- mem_rd_addr  out  ADDR_WDT  BRAM address.
- mem_rd_data  in  DATA_WDT  BRAM data, valid RD_LAT enabled cycles after mem_rd_en.
- out_data  out  DATA_WDT  stream word (FIFO head).
- out_val  out  1  stream valid.
- out_rdy  in  1  stream ready.
- out_last  out  1  marks final word of the command.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse after the last word handshake.

## Operation
- States:
  - IDLE: cmd_rdy=1. On cmd_val&cmd_rdy, latch the base address and length.
    - len=0 → DONE.
    - Otherwise → ISSUE.
  - ISSUE: each enabled cycle with credit available, drive mem_rd_en=1 with the current address, then increment the address and decrement the remaining-to-issue count. After the last issue → DRAIN.
  - DRAIN: wait until the remaining-to-emit count reaches 0 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Credit rule: issue only if inflight + fifo_count < FIFO_DEPTH.
  - inflight is the number of set bits in an RD_LAT-deep valid shift register that mirrors the BRAM latency.
  - The FIFO therefore never overflows. No write is ever dropped.
- The valid shift register's output pushes mem_rd_data into the FIFO.
- out_last is high when the FIFO head is the final word of the command. A per-entry last bit is stored alongside the data.
- Address arithmetic: modulo 2^ADDR_WDT (see Configuration).
- Simultaneous FIFO push and pop in the same cycle: count is unchanged.
- Reset mid-operation: FSM → IDLE, all counters, the FIFO and the valid shift register are cleared. BRAM data still arriving afterwards is ignored because its valid bits were cleared.

## Timing
- Reset values: cmd_rdy=1, mem_rd_en=0, mem_rd_addr=0, out_val=0, out_last=0, out_data=0, busy=0, done=0.
- Command accepted in cycle T:
  - First mem_rd_en in cycle T+1.
  - First out_val in cycle T+RD_LAT+2 (all cycles with clk_en=1, credit available).
- Throughput: one word per cycle when out_rdy is held high and FIFO_DEPTH ≥ RD_LAT+1. Smaller depths stall issue by credit.
- done pulses in the cycle after the handshake of the out_last word. busy falls in the same cycle done rises. cmd_rdy returns the cycle after done.
- out_val, once high, holds with stable out_data/out_last until out_rdy.
- With clk_en=0, nothing advances and no handshakes complete.
- The integrator must set RD_LAT to PIPE_IN_CNT + 1 + PIPE_OUT_CNT of the attached BRAM.

## Configuration
- Macro BRAM_RD_STREAM_RANGE_CHK_EN.
- Defined:
  - A command with cmd_base_addr + cmd_len > 2^ADDR_WDT is rejected.
  - It is consumed in IDLE, no reads are issued, and the FSM goes to DONE.
  - An extra output port cmd_err (1 bit, reset 0) pulses together with done.
- Not defined: no check and no cmd_err port. The address wraps past 2^ADDR_WDT−1 to 0 and all cmd_len words are streamed.

## Test plan
- Basic: BRAM[i]=i, base=5, len=8, out_rdy=1 → words 5..12 in consecutive cycles. out_last on 12. First out_val at T+RD_LAT+2. done one cycle after the word-12 handshake.
- Backpressure: len=16, out_rdy toggles 1-0-0-1 pattern → all 16 words in order with none lost or duplicated. Checker asserts inflight+count ≤ FIFO_DEPTH every cycle.
- Zero length: len=0 → no mem_rd_en, no out_val, done one cycle after accept, cmd_rdy back the next cycle.
- Wrap/check: ADDR_WDT=4, base=14, len=4.
  - Without macro → words 14,15,0,1.
  - With macro → cmd_err=1 with done, zero reads.
- Reset mid-stream: len=32, assert rst after the 5th output word → all outputs at reset values the next cycle, no stray out_val from in-flight reads. A following command base=0, len=2 returns words 0,1 correctly.
- clk_en gating: len=6 with clk_en low every third cycle → the same 6 words in order. Latency counted in enabled cycles only.
